// File: rtl/ternary_conv_pkg.sv
// Shared types and constants for the ternary 3x3 convolution sequencer.
package ternary_conv_pkg;

  localparam int unsigned NTAPS  = 9;
  localparam int unsigned KDIM   = 3;
  localparam int unsigned OFF_W  = 8;
  localparam int unsigned TIDX_W = 4;

  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_NEG  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FETCH,
    DRAIN,
    OUT
  } state_t;

  typedef struct packed {
    logic [OFF_W-1:0] offset;
    logic [1:0]       sign0;
    logic [1:0]       sign1;
  } tap_t;

  function automatic logic w_nonzero(input logic [1:0] w);
    return (w == W_POS) || (w == W_NEG);
  endfunction

  // The unused code 2'b10 collapses to zero.
  function automatic logic [1:0] w_norm(input logic [1:0] w);
    return w_nonzero(w) ? w : W_ZERO;
  endfunction

endpackage

// File: rtl/ternary_conv_sequencer_tap_table.sv
// Ternary weight store plus compaction of nonzero taps into a dense list.
module ternary_tap_table
  import ternary_conv_pkg::*;
#(
  parameter int unsigned IMG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_filt,
  input  logic [3:0]        wr_idx,
  input  logic [1:0]        wr_w,
  input  logic              scan_clear,
  input  logic              scan_en,
  input  logic [TIDX_W-1:0] scan_k,
  input  logic [TIDX_W-1:0] rd_idx,
  output tap_t              rd_entry_c,
  output logic [TIDX_W-1:0] ntaps,
  output logic [TIDX_W-1:0] ntaps_nxt_c
);

  logic [1:0]        w0 [NTAPS];
  logic [1:0]        w1 [NTAPS];
  tap_t              list [NTAPS];
  tap_t              new_entry_c;
  logic              append_c;
  logic [TIDX_W-1:0] ky_c;
  logic [TIDX_W-1:0] kx_c;

  // Candidate entry for tap scan_k; the read port bypasses an entry being appended.
  always_comb begin
    ky_c               = scan_k / TIDX_W'(KDIM);
    kx_c               = scan_k % TIDX_W'(KDIM);
    new_entry_c.offset = OFF_W'(ky_c) * OFF_W'(IMG_W) + OFF_W'(kx_c);
    new_entry_c.sign0  = w_norm(w0[scan_k]);
    new_entry_c.sign1  = w_norm(w1[scan_k]);
    append_c           = scan_en && ((new_entry_c.sign0 != W_ZERO) || (new_entry_c.sign1 != W_ZERO));
    ntaps_nxt_c        = scan_clear ? '0 : ntaps + TIDX_W'(append_c);
    rd_entry_c         = '0;
    if (append_c && (rd_idx == ntaps)) begin
      rd_entry_c = new_entry_c;
    end else if (rd_idx < TIDX_W'(NTAPS)) begin
      rd_entry_c = list[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ntaps <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        w0[TIDX_W'(i)]   <= W_ZERO;
        w1[TIDX_W'(i)]   <= W_ZERO;
        list[TIDX_W'(i)] <= '0;
      end
    end else begin
      if (wr_en && (wr_idx < TIDX_W'(NTAPS))) begin
        if (wr_filt) begin
          w1[wr_idx] <= wr_w;
        end else begin
          w0[wr_idx] <= wr_w;
        end
      end
      if (append_c) begin
        list[ntaps] <= new_entry_c;
      end
      ntaps <= ntaps_nxt_c;
    end
  end

endmodule

// File: rtl/ternary_conv_sequencer.sv
// Sequences a two-filter ternary 3x3 convolution over an activation plane in external RAM.
module ternary_conv_sequencer
  import ternary_conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 5,
  parameter int unsigned IMG_H  = 5,
  parameter int unsigned ACT_W  = 9,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned POS_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic              cfg_filt,
  input  logic [3:0]        cfg_idx,
  input  logic [1:0]        cfg_w,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              act_re,
  output logic [ADDR_W-1:0] act_raddr,
  input  logic [ACT_W-1:0]  act_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POS_W-1:0]  out_pos,
  output logic [ACC_W-1:0]  out_f0,
  output logic [ACC_W-1:0]  out_f1
);

  localparam int unsigned OX_LAST = IMG_W - 3;
  localparam int unsigned OY_LAST = IMG_H - 3;

  state_t            state, state_nxt;
  logic              busy_nxt, done_nxt, act_re_nxt, out_valid_nxt;
  logic [ADDR_W-1:0] act_raddr_nxt;
  logic [POS_W-1:0]  out_pos_nxt;
  logic [ACC_W-1:0]  out_f0_nxt, out_f1_nxt;
  logic [ADDR_W-1:0] ox, oy, ox_nxt, oy_nxt, ox_adv, oy_adv;
  logic [ADDR_W-1:0] base_cur, base_adv, issue_base;
  logic              last_pos, issue;
  logic [TIDX_W-1:0] scan_k, scan_k_nxt, tcnt, tcnt_nxt, issue_t;
  logic [ACC_W-1:0]  acc0, acc1, acc0_nxt, acc1_nxt, acc0_upd, acc1_upd, act_ext;
  logic              acc_en, acc_en_nxt;
  logic [1:0]        acc_s0, acc_s1, acc_s0_nxt, acc_s1_nxt;
  logic [1:0]        tap_s0, tap_s1, tap_s0_nxt, tap_s1_nxt;

  logic              wr_en, scan_clear, scan_en;
  logic [TIDX_W-1:0] rd_idx, ntaps, ntaps_nxt;
  tap_t              rd_entry;

  assign wr_en      = cfg_we && (state == IDLE);
  assign scan_clear = start && (state == IDLE);
  assign scan_en    = (state == SCAN);
  assign rd_idx     = (state == FETCH) ? tcnt : '0;

  ternary_tap_table #(.IMG_W(IMG_W)) u_tap_table (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_filt     (cfg_filt),
    .wr_idx      (cfg_idx),
    .wr_w        (cfg_w),
    .scan_clear  (scan_clear),
    .scan_en     (scan_en),
    .scan_k      (scan_k),
    .rd_idx      (rd_idx),
    .rd_entry_c  (rd_entry),
    .ntaps       (ntaps),
    .ntaps_nxt_c (ntaps_nxt)
  );

  function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc,
                                                input logic [1:0] s,
                                                input logic [ACC_W-1:0] a);
    case (s)
      W_POS:   return acc + a;
      W_NEG:   return acc - a;
      default: return acc;
    endcase
  endfunction

  // Read data of the previous cycle's fetch, folded into both accumulators.
  always_comb begin
    act_ext  = ACC_W'($signed(act_rdata));
    acc0_upd = acc_en ? acc_step(acc0, acc_s0, act_ext) : acc0;
    acc1_upd = acc_en ? acc_step(acc1, acc_s1, act_ext) : acc1;
    last_pos = (ox == ADDR_W'(OX_LAST)) && (oy == ADDR_W'(OY_LAST));
    ox_adv   = (ox == ADDR_W'(OX_LAST)) ? '0 : ox + ADDR_W'(1);
    oy_adv   = (ox == ADDR_W'(OX_LAST)) ? oy + ADDR_W'(1) : oy;
    base_cur = oy * ADDR_W'(IMG_W) + ox;
    base_adv = oy_adv * ADDR_W'(IMG_W) + ox_adv;
  end

  // Next state and next register values; outputs are registered one cycle ahead.
  always_comb begin
    state_nxt     = state;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    act_re_nxt    = 1'b0;
    act_raddr_nxt = act_raddr;
    out_valid_nxt = out_valid;
    out_pos_nxt   = out_pos;
    out_f0_nxt    = out_f0;
    out_f1_nxt    = out_f1;
    ox_nxt        = ox;
    oy_nxt        = oy;
    scan_k_nxt    = scan_k;
    tcnt_nxt      = tcnt;
    acc0_nxt      = acc0_upd;
    acc1_nxt      = acc1_upd;
    acc_en_nxt    = act_re;
    acc_s0_nxt    = tap_s0;
    acc_s1_nxt    = tap_s1;
    tap_s0_nxt    = tap_s0;
    tap_s1_nxt    = tap_s1;
    issue         = 1'b0;
    issue_t       = '0;
    issue_base    = base_cur;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SCAN;
          busy_nxt    = 1'b1;
          scan_k_nxt  = '0;
          ox_nxt      = '0;
          oy_nxt      = '0;
          out_pos_nxt = '0;
          acc0_nxt    = '0;
          acc1_nxt    = '0;
        end
      end
      SCAN: begin
        scan_k_nxt = scan_k + TIDX_W'(1);
        if (scan_k == TIDX_W'(NTAPS - 1)) begin
          if (ntaps_nxt != '0) begin
            state_nxt = FETCH;
            issue     = 1'b1;
          end else begin
            state_nxt     = OUT;
            out_valid_nxt = 1'b1;
            out_f0_nxt    = acc0_upd;
            out_f1_nxt    = acc1_upd;
          end
        end
      end
      FETCH: begin
        if (tcnt == ntaps) begin
          state_nxt = DRAIN;
        end else begin
          issue   = 1'b1;
          issue_t = tcnt;
        end
      end
      DRAIN: begin
        state_nxt     = OUT;
        out_valid_nxt = 1'b1;
        out_f0_nxt    = acc0_upd;
        out_f1_nxt    = acc1_upd;
      end
      OUT: begin
        if (out_ready) begin
          acc0_nxt      = '0;
          acc1_nxt      = '0;
          out_valid_nxt = 1'b0;
          if (last_pos) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            ox_nxt      = ox_adv;
            oy_nxt      = oy_adv;
            out_pos_nxt = out_pos + POS_W'(1);
            if (ntaps != '0) begin
              state_nxt  = FETCH;
              issue      = 1'b1;
              issue_base = base_adv;
            end else begin
              out_valid_nxt = 1'b1;
              out_f0_nxt    = '0;
              out_f1_nxt    = '0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (issue) begin
      act_re_nxt    = 1'b1;
      act_raddr_nxt = issue_base + ADDR_W'(rd_entry.offset);
      tap_s0_nxt    = rd_entry.sign0;
      tap_s1_nxt    = rd_entry.sign1;
      tcnt_nxt      = issue_t + TIDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      act_re    <= 1'b0;
      act_raddr <= '0;
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_f0    <= '0;
      out_f1    <= '0;
      ox        <= '0;
      oy        <= '0;
      scan_k    <= '0;
      tcnt      <= '0;
      acc0      <= '0;
      acc1      <= '0;
      acc_en    <= 1'b0;
      acc_s0    <= W_ZERO;
      acc_s1    <= W_ZERO;
      tap_s0    <= W_ZERO;
      tap_s1    <= W_ZERO;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      act_re    <= act_re_nxt;
      act_raddr <= act_raddr_nxt;
      out_valid <= out_valid_nxt;
      out_pos   <= out_pos_nxt;
      out_f0    <= out_f0_nxt;
      out_f1    <= out_f1_nxt;
      ox        <= ox_nxt;
      oy        <= oy_nxt;
      scan_k    <= scan_k_nxt;
      tcnt      <= tcnt_nxt;
      acc0      <= acc0_nxt;
      acc1      <= acc1_nxt;
      acc_en    <= acc_en_nxt;
      acc_s0    <= acc_s0_nxt;
      acc_s1    <= acc_s1_nxt;
      tap_s0    <= tap_s0_nxt;
      tap_s1    <= tap_s1_nxt;
    end
  end

endmodule

// File: tb/tb_ternary_conv_sequencer.sv
// Directed bench for ternary_conv_sequencer with a 1-cycle-latency activation RAM model.
module tb_ternary_conv_sequencer;
  import ternary_conv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cfg_we, cfg_filt, start, out_ready;
  logic [3:0]  cfg_idx;
  logic [1:0]  cfg_w;
  logic        busy, done, act_re, out_valid;
  logic [4:0]  act_raddr;
  logic [8:0]  act_rdata;
  logic [3:0]  out_pos;
  logic [11:0] out_f0, out_f1;

  ternary_conv_sequencer #(
    .IMG_W(5), .IMG_H(5), .ACT_W(9), .ACC_W(12), .ADDR_W(5), .POS_W(4)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_filt(cfg_filt), .cfg_idx(cfg_idx),
    .cfg_w(cfg_w), .start(start), .busy(busy), .done(done), .act_re(act_re),
    .act_raddr(act_raddr), .act_rdata(act_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pos(out_pos), .out_f0(out_f0), .out_f1(out_f1)
  );

  always #5 clk = ~clk;

  logic [8:0] ram [32];
  always @(posedge clk) if (act_re) act_rdata <= ram[act_raddr];

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [11:0] got_f0 [9];
  logic signed [11:0] got_f1 [9];
  logic [3:0]         got_pos [9];
  int rd_cnt [10];
  int beats, done_cnt, first_valid, busy_at1, reads_in_out, stall_seen, stall_bad, done_busy;
  logic [3:0]  sp;
  logic [11:0] s0, s1;

  task automatic set_w(input logic f, input int idx, input logic [1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_filt = f; cfg_idx = 4'(idx); cfg_w = w;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_all(input logic f, input logic [1:0] w);
    for (int i = 0; i < 9; i++) set_w(f, i, w);
  endtask

  task automatic ram_fill(input bit ramp);
    for (int a = 0; a < 32; a++) ram[a] = ramp ? 9'(a) : 9'd255;
  endtask

  // Runs one pass; cycle 1 is the first cycle after start is sampled.
  task automatic run_pass(input int stall_pos, input int stall_n, input int inject_cyc);
    int cyc = 0;
    int stall_left = stall_n;
    beats = 0; done_cnt = 0; first_valid = -1; busy_at1 = -1; done_busy = -1;
    reads_in_out = 0; stall_seen = 0; stall_bad = 0;
    for (int i = 0; i < 10; i++) rd_cnt[i] = 0;
    for (int i = 0; i < 9; i++) begin got_f0[i] = '0; got_f1[i] = '0; got_pos[i] = '0; end
    @(negedge clk);
    start = 1'b1;
    while (done_cnt == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; cfg_we = 1'b0;
      if (cyc == inject_cyc) begin
        start = 1'b1; cfg_we = 1'b1; cfg_filt = 1'b1; cfg_idx = 4'd4; cfg_w = W_ZERO;
      end
      if (cyc == 1) busy_at1 = int'(busy);
      if (act_re) begin
        if (beats < 10) rd_cnt[beats]++;
        if (out_valid) reads_in_out++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin done_cnt++; done_busy = int'(busy); end
      if (out_valid) begin
        if (beats == stall_pos && stall_left > 0) begin
          if (stall_seen == 0) begin sp = out_pos; s0 = out_f0; s1 = out_f1; end
          else if ({sp, s0, s1} !== {out_pos, out_f0, out_f1}) stall_bad++;
          stall_seen++; stall_left--; out_ready = 1'b0;
        end else begin
          if (beats == stall_pos && stall_seen > 0 && {sp, s0, s1} !== {out_pos, out_f0, out_f1}) stall_bad++;
          out_ready = 1'b1;
          if (beats < 9) begin got_pos[beats] = out_pos; got_f0[beats] = out_f0; got_f1[beats] = out_f1; end
          beats++;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    start = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (done_cnt != 1) $display("FAIL pass_done: done pulses %0d after %0d cycles, required 1", done_cnt, cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_we = 1'b0; cfg_filt = 1'b0; cfg_idx = '0; cfg_w = '0;
    start = 1'b0; out_ready = 1'b1;
    ram_fill(1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, act_re, out_valid} !== 4'b0) $display("FAIL reset_ctrl: busy/done/re/valid %b required 0000", {busy, done, act_re, out_valid});
    else n_pass++;
    n_checks++;
    if ({act_raddr, out_pos, out_f0, out_f1} !== '0) $display("FAIL reset_data: raddr %0d pos %0d f0 %0d f1 %0d required all 0", act_raddr, out_pos, out_f0, out_f1);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Ramp data, w0 all +1, w1 centre -1: f0 = 9*base+54, f1 = -(base+6).
  task automatic test_full_pass();
    int base;
    logic signed [11:0] e0, e1;
    ram_fill(1'b1);
    set_all(1'b0, W_POS);
    set_all(1'b1, W_ZERO);
    set_w(1'b1, 4, W_NEG);
    run_pass(-1, 0, -1);
    n_checks++;
    if (beats != 9) $display("FAIL full_beats: got %0d required 9", beats); else n_pass++;
    n_checks++;
    if (busy_at1 != 1 || done_busy != 0) $display("FAIL full_busy: busy@1 %0d busy@done %0d required 1 0", busy_at1, done_busy);
    else n_pass++;
    // 9 SCAN + 9 FETCH + 1 DRAIN cycles after the first busy cycle.
    n_checks++;
    if (first_valid != 20) $display("FAIL full_latency: first valid at %0d required 20", first_valid); else n_pass++;
    for (int p = 0; p < 9; p++) begin
      base = (p / 3) * 5 + (p % 3);
      e0 = 12'(9 * base + 54);
      e1 = 12'(-(base + 6));
      n_checks++;
      if (got_pos[p] !== 4'(p) || got_f0[p] !== e0 || got_f1[p] !== e1)
        $display("FAIL full_pos%0d: pos %0d f0 %0d f1 %0d required %0d %0d %0d", p, got_pos[p], got_f0[p], got_f1[p], p, e0, e1);
      else n_pass++;
      n_checks++;
      if (rd_cnt[p] != 9) $display("FAIL full_reads%0d: got %0d required 9", p, rd_cnt[p]); else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_pulse: done %b busy %b required 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_zero_weights();
    int total = 0;
    set_all(1'b0, W_ZERO);
    set_all(1'b1, W_ZERO);
    run_pass(-1, 0, -1);
    for (int p = 0; p < 10; p++) total += rd_cnt[p];
    n_checks++;
    if (total != 0) $display("FAIL zero_reads: got %0d required 0", total); else n_pass++;
    n_checks++;
    if (beats != 9 || first_valid != 10) $display("FAIL zero_beats: beats %0d first %0d required 9 10", beats, first_valid);
    else n_pass++;
    for (int p = 0; p < 9; p++) begin
      n_checks++;
      if (got_pos[p] !== 4'(p) || got_f0[p] !== 12'sd0 || got_f1[p] !== 12'sd0)
        $display("FAIL zero_pos%0d: pos %0d f0 %0d f1 %0d required %0d 0 0", p, got_pos[p], got_f0[p], got_f1[p], p);
      else n_pass++;
    end
  endtask

  // w0 tap0=+1, tap8=-1: f0 = base - (base+12) = -12 everywhere; stall 3 cycles at pos4.
  task automatic test_sparse_stall();
    set_w(1'b0, 0, W_POS);
    set_w(1'b0, 8, W_NEG);
    run_pass(4, 3, -1);
    n_checks++;
    if (first_valid != 13) $display("FAIL sparse_latency: got %0d required 13", first_valid); else n_pass++;
    for (int p = 0; p < 9; p++) begin
      n_checks++;
      if (rd_cnt[p] != 2 || got_f0[p] !== -12'sd12 || got_f1[p] !== 12'sd0 || got_pos[p] !== 4'(p))
        $display("FAIL sparse_pos%0d: reads %0d f0 %0d f1 %0d pos %0d required 2 -12 0 %0d", p, rd_cnt[p], got_f0[p], got_f1[p], got_pos[p], p);
      else n_pass++;
    end
    n_checks++;
    if (stall_seen != 3 || stall_bad != 0) $display("FAIL stall_hold: held %0d unstable %0d required 3 0", stall_seen, stall_bad);
    else n_pass++;
    n_checks++;
    if (reads_in_out != 0) $display("FAIL stall_reads: reads during OUT %0d required 0", reads_in_out); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int base;
    logic signed [11:0] e0, e1;
    set_all(1'b0, W_POS);
    set_all(1'b1, W_ZERO);
    set_w(1'b1, 4, W_NEG);
    run_pass(-1, 0, 12);
    n_checks++;
    if (beats != 9) $display("FAIL ignore_beats: got %0d required 9", beats); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ignore_start: busy %b required 0", busy); else n_pass++;
    run_pass(-1, 0, -1);
    for (int p = 0; p < 9; p++) begin
      base = (p / 3) * 5 + (p % 3);
      e0 = 12'(9 * base + 54);
      e1 = 12'(-(base + 6));
      n_checks++;
      if (got_f0[p] !== e0 || got_f1[p] !== e1)
        $display("FAIL ignore_pos%0d: f0 %0d f1 %0d required %0d %0d", p, got_f0[p], got_f1[p], e0, e1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int total = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      if (out_valid && out_pos == 4'd5) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL mid_reach_pos5: position 5 not seen, required within 500 cycles"); else n_pass++;
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, act_re, out_valid, act_raddr, out_pos, out_f0, out_f1} !== '0)
      $display("FAIL mid_reset: busy %b valid %b pos %0d f0 %0d f1 %0d required all 0", busy, out_valid, out_pos, out_f0, out_f1);
    else n_pass++;
    reset = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL mid_idle: busy %b required 0", busy); else n_pass++;
    run_pass(-1, 0, -1);
    for (int p = 0; p < 10; p++) total += rd_cnt[p];
    n_checks++;
    if (total != 0 || beats != 9) $display("FAIL mid_weights_cleared: reads %0d beats %0d required 0 9", total, beats);
    else n_pass++;
    for (int p = 0; p < 9; p++) begin
      n_checks++;
      if (got_f0[p] !== 12'sd0 || got_f1[p] !== 12'sd0)
        $display("FAIL mid_pos%0d: f0 %0d f1 %0d required 0 0", p, got_f0[p], got_f1[p]);
      else n_pass++;
    end
  endtask

  // All 255, w0 all +1: 2295 wraps to -1801; w1 codes 2'b10 act as zero, index 9 is ignored.
  task automatic test_wrap();
    ram_fill(1'b0);
    set_all(1'b0, W_POS);
    set_all(1'b1, 2'b10);
    set_w(1'b1, 9, W_NEG);
    run_pass(-1, 0, -1);
    for (int p = 0; p < 9; p++) begin
      n_checks++;
      if (got_f0[p] !== -12'sd1801 || got_f1[p] !== 12'sd0 || rd_cnt[p] != 9)
        $display("FAIL wrap_pos%0d: f0 %0d f1 %0d reads %0d required -1801 0 9", p, got_f0[p], got_f1[p], rd_cnt[p]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_zero_weights();
    test_sparse_stall();
    test_busy_ignore();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ternary_conv_sequencer.md
Name: ternary_conv_sequencer

Overview:
Controller that sequences the two-filter ternary 3x3 convolution over an IMG_H x IMG_W activation plane held in external single-port RAM. It holds the ternary weights and compacts them into a list of nonzero taps, so zero taps are never fetched. It then walks the output positions in row-major order, issues activation reads, and accumulates +act/-act per filter. Each position's two results are delivered on a valid/ready stream to the downstream pooling/writeback stage.

Parameters:
IMG_W, 5, activation plane width
IMG_H, 5, activation plane height
ACT_W, 9, signed activation width
ACC_W, 12, signed accumulator/result width
ADDR_W, 5, activation RAM address width (>= clog2(IMG_W*IMG_H))
POS_W, 4, output position index width (>= clog2((IMG_H-2)*(IMG_W-2)))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  weight write strobe
cfg_filt  in  1  filter select (0/1)
cfg_idx  in  4  tap index 0..8 (ky*3+kx); values 9..15 ignored
cfg_w  in  2  signed ternary weight (+1, 0, -1)
start  in  1  begin a full plane pass
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass
act_re  out  1  activation read strobe
act_raddr  out  ADDR_W  activation read address
act_rdata  in  ACT_W  signed read data, valid exactly 1 cycle after act_re
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_pos  out  POS_W  output position index, row-major
out_f0  out  ACC_W  filter 0 result
out_f1  out  ACC_W  filter 1 result

Behaviour:
- Reset values: all weights 0. State IDLE. busy=0, done=0, act_re=0, act_raddr=0, out_valid=0, out_pos=0, out_f0=0, out_f1=0. Tap list empty.
- Reset mid-pass aborts immediately with the same values. The weights are cleared too.
- cfg_we is honoured only in IDLE; it is ignored while busy. Weight code 2'b10 is stored but treated as 0.
- start is honoured only in IDLE; it is ignored while busy. If start and cfg_we arrive in the same IDLE cycle, the write is taken and start uses the new weight.
- States:
  - IDLE: wait for start, then go to SCAN. busy is high from the next cycle.
  - SCAN: 9 cycles, k=0..8. Append tap k when w0[k]!=0 or w1[k]!=0. The entry stores the offset ky*IMG_W+kx and both signs. Result is N taps (0..9). Go to FETCH if N>0, otherwise to OUT.
  - FETCH: N cycles. Tap t: act_re=1, act_raddr = base + offset[t], where base = oy*IMG_W+ox.
  - DRAIN: 1 cycle. Absorbs the last read's data, then go to OUT.
  - OUT: out_valid=1. out_pos, out_f0 and out_f1 are held stable until out_ready. No reads are issued in OUT.
  - On handshake, clear the accumulators and advance to the next position: FETCH, or OUT again when N=0. After the last position, go to IDLE with done pulsed that cycle; busy drops the same cycle.
- Accumulate: in the cycle after each act_re, sign-extend act_rdata to ACC_W.
  - acc_f += act for w=+1; acc_f -= act for w=-1; unchanged for w=0.
  - Both filters update in parallel.
  - Two's-complement wrap mod 2^ACC_W; there is no saturation.
- Timing per position with N>0: N+1 cycles, plus at least 1 OUT cycle. The first pass result appears 9+N+1 cycles after start.
- Position order: ox is the fast index over 0..IMG_W-3, oy over 0..IMG_H-3. out_pos = oy*(IMG_W-2)+ox.
- Weights persist across passes. SCAN rebuilds the tap list at every start.

Decomposition:
- Package ternary_conv_pkg holds:
  - the state enum (IDLE, SCAN, FETCH, DRAIN, OUT);
  - NTAPS=9 and KDIM=3;
  - ternary codes W_POS=2'b01, W_ZERO=2'b00, W_NEG=2'b11;
  - the tap-entry struct (offset, sign0, sign1).
- Sub-module ternary_tap_table holds the weight registers, the SCAN compaction, and the N-entry tap list with a read port indexed by t.

Test Plan:
- Act RAM[a]=a (a=0..24); w0 all +1; w1 centre=-1, others 0 -> pos0: f0=54, f1=-6; pos8: f0=162, f1=-18; N=9; 9 beats, then done.
- All weights 0 -> SCAN gives N=0, act_re never asserts, 9 beats all f0=f1=0, out_pos 0..8 in order.
- Same data; w0 tap0=+1, tap8=-1; w1 0 -> N=2, act_re exactly 2 per position, pos4 (base 6): f0=6-18=-12, f1=0.
- At pos4, hold out_ready=0 for 3 cycles -> out_valid and data stable, act_re=0 throughout, accepted on the 4th cycle.
- Pulse start and cfg_we during FETCH -> both ignored, results unchanged. Assert reset at pos5 -> next cycle all outputs 0, weights 0, state IDLE.
- RAM all 255 (ACT_W=9), w0 all +1 -> f0 = 2295 mod 4096 as signed 12-bit = -1801 (wrap checked).
